// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit words into byte-addressed instruction memory, big-endian, one byte per cycle
// Ports: clk/reset (sync, active-high); start+base_addr open a session; in_valid/in_ready/in_word/in_last word stream;
//        mem_we/mem_addr/mem_wdata byte write port; busy/done/overflow/words_written session status.
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] words_written
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr;
  logic [1:0] idx;
  logic [31:0] word_q;
  logic last_q;
  logic [ADDR_W:0] ptr_end;
  logic room, restart;
  // one extra bit so a pointer near the top of the address space cannot wrap past the check
  assign ptr_end = {1'b0, ptr} + (ADDR_W+1)'(4);
  assign room = ptr_end <= (ADDR_W+1)'(DEPTH);
  assign restart = start && (state == IDLE || state == DONE);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (restart) nxt = ACCEPT;
    else if (state == ACCEPT) nxt = !room ? DONE : (in_valid ? WRITE : ACCEPT);
    else if (state == WRITE && idx == 2'd3) nxt = last_q ? DONE : ACCEPT;
  end
  assign in_ready = state == ACCEPT && room;
  assign mem_we = state == WRITE;
  assign busy = state == ACCEPT || state == WRITE;
  assign done = state == DONE;
  assign mem_addr = mem_we ? ptr + ADDR_W'(idx) : '0;
  // ~idx selects byte 3-idx, so idx 0 emits bits [31:24]
  assign mem_wdata = mem_we ? word_q[{~idx, 3'b000} +: 8] : 8'h00;
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      idx <= '0;
      word_q <= '0;
      last_q <= 1'b0;
      overflow <= 1'b0;
      words_written <= '0;
    end else begin
      if (restart) begin
        ptr <= {base_addr[ADDR_W-1:2], 2'b00};
        words_written <= '0;
        overflow <= 1'b0;
      end
      if (state == ACCEPT && !room) overflow <= 1'b1;
      if (in_valid && in_ready) begin
        word_q <= in_word;
        last_q <= in_last;
        idx <= '0;
      end
      if (state == WRITE) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          ptr <= ptr + ADDR_W'(4);
          words_written <= words_written + ADDR_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
  logic [9:0] base_addr = '0;
  logic [31:0] in_word = '0;
  logic in_ready, mem_we, busy, done, overflow;
  logic [9:0] mem_addr, words_written;
  logic [7:0] mem_wdata;
  int n_cmp = 0, n_bad = 0, ready_in_write = 0;
  int log_a[$], log_d[$], exp_a[$], exp_d[$];

  instr_mem_loader #(.ADDR_W(10), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow), .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      log_a.push_back(int'(mem_addr));
      log_d.push_back(int'(mem_wdata));
    end
    if (mem_we && in_ready) ready_in_write++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(a + i);
      exp_d.push_back(int'(w[31-8*i -: 8]));
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwrites"}, log_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_a[i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), log_d[i], exp_d[i]);
    end
    log_a.delete(); log_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_ww"}, words_written, 0);
  endtask

  task automatic pulse_start(input logic [9:0] b);
    start = 1; base_addr = b;
    tick();
    start = 0;
  endtask

  // returns in the first byte-write cycle of the accepted word
  task automatic send(input logic [31:0] w, input logic l);
    int n = 0;
    in_valid = 1; in_word = w; in_last = l;
    while (!in_ready && n < 30) begin tick(); n++; end
    chk("hs_timeout", n < 30, 1);
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    tick(); tick();
    check_reset("rst");
    reset = 0;
    tick();
    // 1: single word
    pulse_start(10'd0);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    send(32'hDEADBEEF, 1);
    chk("t1_we0", mem_we, 1);
    chk("t1_addr0", mem_addr, 0);
    chk("t1_data0", mem_wdata, 8'hDE);
    tick(); tick(); tick();
    chk("t1_data3", mem_wdata, 8'hEF);
    tick();
    chk("t1_done", done, 1);
    chk("t1_ww", words_written, 1);
    chk("t1_busy_off", busy, 0);
    exp_word(0, 32'hDEADBEEF);
    check_log("t1");
    // 2: unaligned base
    pulse_start(10'h00E);
    send(32'h01234567, 0);
    send(32'h89ABCDEF, 1);
    wait_done();
    chk("t2_ww", words_written, 2);
    exp_word(12, 32'h01234567);
    exp_word(16, 32'h89ABCDEF);
    check_log("t2");
    // 3: valid during WRITE and gaps between words
    pulse_start(10'h020);
    send(32'hA1B2C3D4, 0);
    in_valid = 1; in_word = 32'h0BAD0BAD;
    chk("t3_ready_in_write", in_ready, 0);
    tick(); tick(); tick();
    in_valid = 0;
    tick();
    tick(); tick(); tick();
    chk("t3_ww_mid", words_written, 1);
    chk("t3_ready_gap", in_ready, 1);
    send(32'h55AA33CC, 1);
    wait_done();
    chk("t3_ww", words_written, 2);
    exp_word(32, 32'hA1B2C3D4);
    exp_word(36, 32'h55AA33CC);
    check_log("t3");
    // 4: fill to exact top, third word refused
    pulse_start(10'd56);
    send(32'h11111111, 0);
    send(32'h22222222, 0);
    in_valid = 1; in_word = 32'h33333333;
    wait_done();
    in_valid = 0;
    chk("t4_ovf", overflow, 1);
    chk("t4_ready", in_ready, 0);
    chk("t4_ww", words_written, 2);
    exp_word(56, 32'h11111111);
    exp_word(60, 32'h22222222);
    check_log("t4");
    // 5: reset on second byte cycle
    pulse_start(10'd0);
    send(32'h11223344, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    check_reset("t5_rst");
    tick();
    chk("t5_we_after", mem_we, 0);
    exp_a.push_back(0); exp_d.push_back(8'h11);
    exp_a.push_back(1); exp_d.push_back(8'h22);
    check_log("t5a");
    pulse_start(10'd4);
    send(32'h55667788, 1);
    wait_done();
    chk("t5_ww", words_written, 1);
    exp_word(4, 32'h55667788);
    check_log("t5b");
    // 6: out-of-range base, then start ignored while busy
    pulse_start(10'd64);
    chk("t6_oor_ready", in_ready, 0);
    chk("t6_oor_busy", busy, 1);
    tick();
    chk("t6_oor_done", done, 1);
    chk("t6_oor_ovf", overflow, 1);
    chk("t6_oor_ww", words_written, 0);
    pulse_start(10'd0);
    chk("t6_ovf_clr", overflow, 0);
    chk("t6_done_clr", done, 0);
    send(32'hCAFEF00D, 1);
    pulse_start(10'h020);
    chk("t6_still_write", mem_we, 1);
    wait_done();
    chk("t6_ww", words_written, 1);
    exp_word(0, 32'hCAFEF00D);
    check_log("t6a");
    pulse_start(10'h020);
    chk("t6_ww_clr", words_written, 0);
    chk("t6_restart_ready", in_ready, 1);
    send(32'h0F1E2D3C, 1);
    wait_done();
    exp_word(32, 32'h0F1E2D3C);
    check_log("t6b");
    chk("ready_during_write", ready_in_write, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
